// File: rtl/counter_pkg.sv
// Shared definitions for the dual-edge counter family: FSM state encoding.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_negedge_cell.sv
// Falling-edge incrementer holding the half of the count advanced on negedge.
module counter_negedge_cell #(
    parameter int N = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q;

    // Only ever cleared by the async reset; posedge logic re-bases against a snapshot instead.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + N'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counterdownn_1clk_dualedge_async_resetn.sv
// Loadable down-counter stepping on both clock edges, flags done at zero.
// Optional COUNTER_RELOAD_EN: wrap back to the loaded value and pulse tc instead of finishing.
module counterdownn_1clk_dualedge_async_resetn
    import counter_pkg::*;
#(
    parameter int n = 12
) (
    input  logic         clk,
    input  logic         rst_counter_n,
    input  logic         load,
    input  logic [n-1:0] load_value,
    input  logic         en,
    output logic [n-1:0] q_counter,
    output logic         busy,
    output logic         done,
    output logic         tc
);

    state_t       state_q, state_d;
    logic [n-1:0] start_q, start_d;
    logic [n-1:0] posCnt_q, posCnt_d;
    logic [n-1:0] negBase_q, negBase_d;
    logic         tc_q, tc_d;
    logic [n-1:0] negCnt;
    logic         runEn;

    counter_negedge_cell #(.N(n)) u_negCell (
        .clk_i   (clk),
        .rst_ni  (rst_counter_n),
        .inc_i   (runEn),
        .count_o (negCnt)
    );

    // Steps taken on negedge since the last load are negCnt - negBase_q.
    assign q_counter = start_q - (posCnt_q + (negCnt - negBase_q));
    assign runEn     = (state_q == ST_RUN) && en && (q_counter != '0);

    always_ff @(posedge clk or negedge rst_counter_n) begin
        if (!rst_counter_n) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            posCnt_q  <= '0;
            negBase_q <= '0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            posCnt_q  <= posCnt_d;
            negBase_q <= negBase_d;
            tc_q      <= tc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        posCnt_d  = posCnt_q;
        negBase_d = negBase_q;
        tc_d      = 1'b0;
        if (load) begin
            start_d   = load_value;
            posCnt_d  = '0;
            negBase_d = negCnt;
            state_d   = (load_value == '0) ? ST_DONE : ST_RUN;
        end else begin
            if (runEn) begin
                posCnt_d = posCnt_q + n'(1);
            end
            if ((state_q == ST_RUN) && (q_counter == '0)) begin
`ifdef COUNTER_RELOAD_EN
                posCnt_d  = '0;
                negBase_d = negCnt;
                tc_d      = 1'b1;
`else
                state_d   = ST_DONE;
`endif
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        tc   = tc_q;
    end

endmodule
